serial_adder: RTL and testbench
===============================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand/result width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request to begin an addition; sampled only when busy=0.
REQ-005 SHALL have port a  input  WIDTH  operand A; captured on the accepting edge.
REQ-006 SHALL have port b  input  WIDTH  operand B; captured on the accepting edge.
REQ-007 SHALL have port cin  input  1  carry-in; captured on the accepting edge.
REQ-008 SHALL have port busy  output  1  high while an addition is in progress (state RUN or DONE).
REQ-009 SHALL have port done  output  1  one-cycle pulse marking valid sum/cout.
REQ-010 SHALL have port sum  output  WIDTH  registered result, held until the next completed addition.
REQ-011 SHALL have port cout  output  1  registered carry-out, held with sum.

Function
REQ-012 SHALL implement an FSM with states IDLE, RUN, DONE.
REQ-013 IDLE->RUN SHALL occur on the rising edge where start=1 and state=IDLE: load a, b into shift registers, cin into carry flop, clear bit counter.
REQ-014 In RUN, each edge SHALL add the LSBs of both shift registers and the carry flop in one full-adder cell, shift the sum bit into the MSB of the result shift register, update the carry flop, shift operands right by one, and increment the counter.
REQ-015 RUN->DONE SHALL occur on the edge that processes bit WIDTH-1 (counter = WIDTH-1); on that edge sum and cout SHALL be updated with the full result.
REQ-016 done SHALL be 1 for exactly the one cycle in DONE; DONE->IDLE unconditionally on the next edge.
REQ-017 Latency: start accepted at edge k -> done high in the cycle after edge k+WIDTH; throughput one addition per WIDTH+2 cycles.
REQ-018 start while busy=1 (RUN or DONE) SHALL be ignored, with no effect on operands or outputs.
REQ-019 Arithmetic SHALL be unsigned: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1).
REQ-020 sum/cout SHALL change only on the RUN->DONE edge; intermediate shift-register contents SHALL NOT appear on sum.
REQ-021 a, b, cin changing after acceptance SHALL NOT affect the result in progress.

Reset
REQ-022 rst=1 SHALL immediately force state=IDLE, busy=0, done=0, sum=0, cout=0, and clear counter, carry flop, and all shift registers.
REQ-023 rst asserted mid-RUN SHALL abort the operation; no done pulse SHALL follow, and sum keeps its reset value of 0.
REQ-024 The first start accepted after rst deasserts SHALL behave exactly as REQ-013.

Structure
REQ-025 A package serial_adder_pkg SHALL hold the state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10) and the default WIDTH constant.
REQ-026 The bit-level add SHALL be a single instantiated sub-module fa_cell (inputs x, y, ci; outputs s, co; purely combinational), instantiated once.
REQ-027 Counter width SHALL be $clog2(WIDTH); no other arithmetic operators SHALL be used in the datapath.

Verification (WIDTH=8)
REQ-028 a=0x5A, b=0x33, cin=0, start pulse -> done exactly 8 cycles after the accepting edge; sum=0x8D, cout=0.
REQ-029 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; then a=0xFF, b=0xFF, cin=1 -> sum=0xFF, cout=1.
REQ-030 start held high continuously with a=0x10, b=0x20 -> additions accepted every 10 cycles, each done giving sum=0x30, cout=0; no acceptance while busy=1.
REQ-031 Change a/b to 0x00 two cycles after acceptance of 0x0F+0x01 -> result is still sum=0x10.
REQ-032 Assert rst at RUN bit 4 of 0xAA+0x55 -> busy, done, sum, cout all 0 immediately; no done pulse afterwards; next start 0x01+0x01 gives sum=0x02.
REQ-033 Random a, b, cin over 1000 transactions checked against the reference model of REQ-019, with done pulse width exactly 1 cycle.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int WIDTH_DEF = 8;

endpackage

// File: rtl/serial_adder_fa_cell.sv
// Single-bit full adder; the only adder in the serial datapath.
module fa_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one operand bit per clock through a single full adder,
// with the full result published to sum/cout only when the last bit is done.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_t state_q, state_d;
    logic   load, step, last;

    logic [WIDTH-1:0] a_sr, b_sr;
    logic [WIDTH-2:0] res_sr;
    logic [WIDTH-1:0] res_cat;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             fa_s, fa_co;

    fa_cell u_fa (
        .x  (a_sr[0]),
        .y  (b_sr[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // res_sr only needs WIDTH-1 bits: the final sum bit goes straight to sum.
    assign res_cat = {fa_s, res_sr};
    assign last    = (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                step = 1'b1;
                if (last) state_d = DONE;
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else if (load) begin
            a_sr   <= a;
            b_sr   <= b;
            carry  <= cin;
            cnt    <= '0;
            res_sr <= '0;
        end else if (step) begin
            a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
            res_sr <= res_cat[WIDTH-1:1];
            carry  <= fa_co;
            cnt    <= cnt + CNT_ONE;
            if (last) begin
                sum  <= res_cat;
                cout <= fa_co;
            end
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Randomized and directed checks of serial_adder (WIDTH=8) against an arithmetic reference.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic         cin = 1'b0;
    logic         busy, done, cout;
    logic [W-1:0] sum;

    int           checks = 0;
    int           errors = 0;
    logic [W:0]   prev_res = '0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One transaction from IDLE; scr = cycle after acceptance at which inputs are disturbed
    // (zero=1 forces them to 0), noise toggles start randomly while busy.
    task automatic run_add(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                           input int scr, input bit zero, input bit noise);
        logic [W:0] exp;
        int         n;
        exp = {1'b0, xa} + {1'b0, xb} + {{W{1'b0}}, xc};
        @(negedge clk);
        chk("idle_before", {31'b0, busy}, 32'd0);
        a = xa; b = xb; cin = xc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_run", {31'b0, busy}, 32'd1);
        n = 0;
        while (!done && n < 20) begin
            if (n == scr) begin
                if (zero) begin a = '0; b = '0; cin = 1'b0; end
                else begin a = W'($urandom); b = W'($urandom); cin = 1'($urandom); end
            end
            if (noise) start = 1'($urandom);
            chk("sum_hold", {23'b0, cout, sum}, {23'b0, prev_res});
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk("latency", n, 8);
        chk("sum", {24'b0, sum}, {24'b0, exp[W-1:0]});
        chk("cout", {31'b0, cout}, {31'b0, exp[W]});
        prev_res = exp;
        @(negedge clk);
        chk("done_width", {31'b0, done}, 32'd0);
        chk("idle_after", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int last_done, cyc, ndone;

        // reset state
        #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_sum", {24'b0, sum}, 32'd0);
        chk("rst_cout", {31'b0, cout}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // directed vectors
        run_add(8'h5A, 8'h33, 1'b0, -1, 1'b0, 1'b0);
        run_add(8'hFF, 8'h01, 1'b0, -1, 1'b0, 1'b0);
        run_add(8'hFF, 8'hFF, 1'b1, -1, 1'b0, 1'b0);
        run_add(8'h0F, 8'h01, 1'b0, 2, 1'b1, 1'b0);

        // start held high: one acceptance every 10 cycles
        @(negedge clk);
        a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
        last_done = -1; ndone = 0;
        for (cyc = 0; cyc < 45; cyc++) begin
            @(negedge clk);
            if (done) begin
                chk("hold_sum", {23'b0, cout, sum}, 32'h030);
                if (last_done >= 0) chk("hold_period", cyc - last_done, 10);
                last_done = cyc;
                ndone++;
            end
        end
        chk("hold_count", ndone, 4);
        start = 1'b0;
        repeat (12) @(negedge clk);
        prev_res = 9'h030;

        // reset in the middle of a run
        a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_done", {31'b0, done}, 32'd0);
        chk("abort_sum", {24'b0, sum}, 32'd0);
        chk("abort_cout", {31'b0, cout}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("abort_no_done", ndone, 0);
        chk("abort_sum_hold", {24'b0, sum}, 32'd0);
        prev_res = '0;
        run_add(8'h01, 8'h01, 1'b0, -1, 1'b0, 1'b0);

        // random transactions with input disturbance and start noise while busy
        for (int i = 0; i < 1000; i++)
            run_add(W'($urandom), W'($urandom), 1'($urandom),
                    int'($urandom_range(0, 9)), 1'b0, 1'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
